// File: rtl/fetch_pc_unit_if.sv
// Decode-side bus of the fetch stage: {pc, instr, prediction} offered under a
// valid/ready handshake. The fetch unit is the master, decode is the slave.
interface fetch_pc_unit_if #(
  parameter int PC_W = 64
);
  logic            valid_o;
  logic            ready_i;
  logic [PC_W-1:0] pc_o;
  logic [31:0]     instr_o;
  logic            pred_taken_o;
  logic [PC_W-1:0] pred_target_o;

  modport master (
    output valid_o, pc_o, instr_o, pred_taken_o, pred_target_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, pc_o, instr_o, pred_taken_o, pred_target_o,
    output ready_i
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: direct-mapped BTB with 2-bit counters, redirect
// handling and a one-entry valid/ready output register towards decode.
module fetch_pc_unit #(
  parameter int              PC_W        = 64,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_VEC   = {PC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_addr_i,
  input  logic              fence_i,
  input  logic              upd_en_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic              upd_taken_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  fetch_pc_unit_if.master   dec_if
);
  localparam int          IDX_W = $clog2(BTB_ENTRIES);
  localparam int          TAG_W = PC_W - IDX_W - 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_out_q, pc_out_d;
  logic [31:0]      instr_q, instr_d;
  logic             pred_taken_q, pred_taken_d;
  logic [PC_W-1:0]  pred_tgt_q, pred_tgt_d;

  logic             btb_vld_q [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
  logic [PC_W-1:0]  btb_tgt_q [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx_s, upd_idx_s;
  logic [TAG_W-1:0] lk_tag_s, upd_tag_s;
  logic             lk_hit_s, lk_taken_s, upd_hit_s, adv_s;
  logic [PC_W-1:0]  npc_s;
  logic             unused_s;

  // Address bits [1:0] of redirect/update PCs carry no information.
  assign unused_s = ^{redirect_addr_i[1:0], upd_pc_i[1:0]};

  assign imem_addr_o          = pc_q;
  assign dec_if.valid_o       = valid_q;
  assign dec_if.pc_o          = pc_out_q;
  assign dec_if.instr_o       = instr_q;
  assign dec_if.pred_taken_o  = pred_taken_q;
  assign dec_if.pred_target_o = pred_tgt_q;

  assign adv_s = instr_valid_i && (!valid_q || dec_if.ready_i);

  // BTB lookup on the current fetch PC and training-port hit detection.
  always_comb begin
    lk_idx_s   = pc_q[IDX_W+1:2];
    lk_tag_s   = pc_q[PC_W-1:IDX_W+2];
    lk_hit_s   = btb_vld_q[lk_idx_s] && (btb_tag_q[lk_idx_s] == lk_tag_s);
    lk_taken_s = lk_hit_s && btb_ctr_q[lk_idx_s][1];
    if (lk_taken_s) begin
      npc_s = btb_tgt_q[lk_idx_s];
    end else begin
      npc_s = pc_q + PC_W'(3'd4);
    end
    upd_idx_s = upd_pc_i[IDX_W+1:2];
    upd_tag_s = upd_pc_i[PC_W-1:IDX_W+2];
    upd_hit_s = btb_vld_q[upd_idx_s] && (btb_tag_q[upd_idx_s] == upd_tag_s);
  end

  // Next fetch PC and output register: redirect beats advance beats drain.
  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    pc_out_d     = pc_out_q;
    instr_d      = instr_q;
    pred_taken_d = pred_taken_q;
    pred_tgt_d   = pred_tgt_q;
    if (redirect_i) begin
      pc_d    = {redirect_addr_i[PC_W-1:2], 2'b00};
      valid_d = 1'b0;
    end else if (adv_s) begin
      pc_d         = npc_s;
      valid_d      = 1'b1;
      pc_out_d     = pc_q;
      instr_d      = instr_i;
      pred_taken_d = lk_taken_s;
      pred_tgt_d   = lk_taken_s ? btb_tgt_q[lk_idx_s] : {PC_W{1'b0}};
    end else if (valid_q && dec_if.ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Fetch PC and decode output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_VEC;
      valid_q      <= 1'b0;
      pc_out_q     <= {PC_W{1'b0}};
      instr_q      <= NOP;
      pred_taken_q <= 1'b0;
      pred_tgt_q   <= {PC_W{1'b0}};
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      pred_taken_q <= pred_taken_d;
      pred_tgt_q   <= pred_tgt_d;
    end
  end

  // BTB storage: fence wipes everything and swallows a same-cycle update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        btb_tag_q[i] <= {TAG_W{1'b0}};
        btb_tgt_q[i] <= {PC_W{1'b0}};
        btb_ctr_q[i] <= 2'b01;
      end
    end else if (fence_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        btb_ctr_q[i] <= 2'b01;
      end
    end else if (upd_en_i) begin
      if (upd_hit_s) begin
        if (upd_taken_i) begin
          btb_tgt_q[upd_idx_s] <= upd_target_i;
          if (btb_ctr_q[upd_idx_s] != 2'b11) begin
            btb_ctr_q[upd_idx_s] <= btb_ctr_q[upd_idx_s] + 2'b01;
          end
        end else if (btb_ctr_q[upd_idx_s] != 2'b00) begin
          btb_ctr_q[upd_idx_s] <= btb_ctr_q[upd_idx_s] - 2'b01;
        end
      end else if (upd_taken_i) begin
        btb_vld_q[upd_idx_s] <= 1'b1;
        btb_tag_q[upd_idx_s] <= upd_tag_s;
        btb_tgt_q[upd_idx_s] <= upd_target_i;
        btb_ctr_q[upd_idx_s] <= 2'b10;
      end
    end
  end
endmodule
